// File: rtl/proc_mem_arbiter_pkg.sv
// Shared types and constants for the processor / DMA data-memory arbiter.
package proc_mem_arb_package;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } proc_mem_arb_state_t;

    typedef enum logic {
        REQ_PROC = 1'b0,
        REQ_DMA  = 1'b1
    } proc_mem_arb_id_t;

endpackage

// File: rtl/proc_mem_arbiter_if.sv
// Bundle of both requester handshakes plus the single data-memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface proc_mem_arbiter_if;
    import proc_mem_arb_package::*;

    // Processor requester
    logic              p_req_sig;
    logic [ADDR_W-1:0] p_addr_sig;
    logic [DATA_W-1:0] p_wdata_sig;
    logic              p_wen_sig;
    logic              p_ack_sig;
    logic [DATA_W-1:0] p_rdata_sig;

    // DMA / debug-loader requester
    logic              d_req_sig;
    logic [ADDR_W-1:0] d_addr_sig;
    logic [DATA_W-1:0] d_wdata_sig;
    logic              d_wen_sig;
    logic              d_ack_sig;
    logic [DATA_W-1:0] d_rdata_sig;

    // Memory port and trace
    logic [ADDR_W-1:0] mem_addr_sig;
    logic [DATA_W-1:0] mem_wdata_sig;
    logic              mem_wen_sig;
    logic [DATA_W-1:0] mem_rdata_sig;
    logic              gnt_id_sig;

    modport slave (
        input  p_req_sig, p_addr_sig, p_wdata_sig, p_wen_sig,
        input  d_req_sig, d_addr_sig, d_wdata_sig, d_wen_sig,
        input  mem_rdata_sig,
        output p_ack_sig, p_rdata_sig, d_ack_sig, d_rdata_sig,
        output mem_addr_sig, mem_wdata_sig, mem_wen_sig, gnt_id_sig
    );

    modport master (
        output p_req_sig, p_addr_sig, p_wdata_sig, p_wen_sig,
        output d_req_sig, d_addr_sig, d_wdata_sig, d_wen_sig,
        output mem_rdata_sig,
        input  p_ack_sig, p_rdata_sig, d_ack_sig, d_rdata_sig,
        input  mem_addr_sig, mem_wdata_sig, mem_wen_sig, gnt_id_sig
    );

endinterface

// File: rtl/proc_mem_arbiter_select.sv
// Combinational winner selection between the processor and DMA requests.
// Build option: PROC_MEM_ARB_RR_EN selects round-robin tie breaking;
// otherwise the processor wins every tie.
module proc_mem_arb_select
    import proc_mem_arb_package::*;
(
    input  logic             p_req_i,
    input  logic             d_req_i,
    input  logic [1:0]       excl_i,   // bit 0 = processor, bit 1 = DMA
    input  proc_mem_arb_id_t last_i,   // requester granted most recently
    output logic             valid_o,
    output proc_mem_arb_id_t win_o
);

    logic p_ok;
    logic d_ok;

    assign p_ok    = p_req_i & ~excl_i[0];
    assign d_ok    = d_req_i & ~excl_i[1];
    assign valid_o = p_ok | d_ok;

`ifndef PROC_MEM_ARB_RR_EN
    // Fixed priority never consults the last-winner pointer.
    logic unused_last;
    assign unused_last = last_i;
`endif

    // Pick the winner among the non-excluded requests.
    always_comb begin
        // NOTE: default first so every path assigns win_o and no latch is inferred.
        win_o = REQ_PROC;
        if (p_ok && d_ok) begin
`ifdef PROC_MEM_ARB_RR_EN
            win_o = (last_i == REQ_PROC) ? REQ_DMA : REQ_PROC;
`else
            win_o = REQ_PROC;
`endif
        end else if (d_ok) begin
            win_o = REQ_DMA;
        end
    end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Shares one registered 8-bit data-memory port between the processor and a
// DMA requester: IDLE -> ACCESS (memory driven) -> RESP (ack + read data).
// Build option: PROC_MEM_ARB_RR_EN (round-robin ties, see the selector).
module proc_mem_arbiter
    import proc_mem_arb_package::*;
(
    input  logic                clk,
    input  logic                rst,
    proc_mem_arbiter_if.slave   bus
);

    proc_mem_arb_state_t state_q, state_d;
    proc_mem_arb_id_t    gnt_q, gnt_d;
    proc_mem_arb_id_t    last_q, last_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wen_q, mem_wen_d;
    logic                op_wen_q, op_wen_d;     // direction of the access in flight
    logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic [1:0]          excl;
    logic                sel_valid;
    proc_mem_arb_id_t    sel_win;
    logic                grant;
    logic                p_ack;
    logic                d_ack;

    // The requester being acked still holds req this cycle, so hide it from
    // the RESP-state arbitration; this also keeps either side from starving.
    assign excl[0] = (state_q == RESP) && (gnt_q == REQ_PROC);
    assign excl[1] = (state_q == RESP) && (gnt_q == REQ_DMA);

    proc_mem_arb_select u_select (
        .p_req_i (bus.p_req_sig),
        .d_req_i (bus.d_req_sig),
        .excl_i  (excl),
        .last_i  (last_q),
        .valid_o (sel_valid),
        .win_o   (sel_win)
    );

    // Next-state logic: sequence the access, capture read data, latch a new winner.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = 1'b0;
        op_wen_d    = op_wen_q;
        p_rdata_d   = p_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant       = 1'b0;

        case (state_q)
            IDLE: begin
                grant = sel_valid;
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (!op_wen_q) begin
                    if (gnt_q == REQ_PROC) p_rdata_d = bus.mem_rdata_sig;
                    else                   d_rdata_d = bus.mem_rdata_sig;
                end
                state_d = IDLE;
                grant   = sel_valid;
            end
            default: state_d = IDLE;
        endcase

        // Latching the winner loads the memory-port registers, so they are
        // presented during ACCESS and hold their values afterwards.
        if (grant) begin
            state_d = ACCESS;
            gnt_d   = sel_win;
            last_d  = sel_win;
            if (sel_win == REQ_PROC) begin
                mem_addr_d  = bus.p_addr_sig;
                mem_wdata_d = bus.p_wdata_sig;
                mem_wen_d   = bus.p_wen_sig;
                op_wen_d    = bus.p_wen_sig;
            end else begin
                mem_addr_d  = bus.d_addr_sig;
                mem_wdata_d = bus.d_wdata_sig;
                mem_wen_d   = bus.d_wen_sig;
                op_wen_d    = bus.d_wen_sig;
            end
        end
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= IDLE;
            gnt_q       <= REQ_PROC;
            last_q      <= REQ_DMA;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
            op_wen_q    <= 1'b0;
            p_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            op_wen_q    <= op_wen_d;
            p_rdata_q   <= p_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign p_ack = (state_q == RESP) && (gnt_q == REQ_PROC);
    assign d_ack = (state_q == RESP) && (gnt_q == REQ_DMA);

    // Memory data arrives in RESP, so a read ack forwards it directly; the
    // holding register takes over from the next cycle.
    assign bus.p_ack_sig     = p_ack;
    assign bus.d_ack_sig     = d_ack;
    assign bus.p_rdata_sig   = (p_ack && !op_wen_q) ? bus.mem_rdata_sig : p_rdata_q;
    assign bus.d_rdata_sig   = (d_ack && !op_wen_q) ? bus.mem_rdata_sig : d_rdata_q;
    assign bus.mem_addr_sig  = mem_addr_q;
    assign bus.mem_wdata_sig = mem_wdata_q;
    assign bus.mem_wen_sig   = mem_wen_q;
    assign bus.gnt_id_sig    = gnt_q;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed testbench for proc_mem_arbiter with a registered memory model.
// Honours PROC_MEM_ARB_RR_EN for tie-break expectations.
module tb_proc_mem_arbiter;
    import proc_mem_arb_package::*;

    logic clk;
    logic rst;
    proc_mem_arbiter_if bus();

    proc_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]       mem [256];
    int               n_checks;
    int               n_fail;
    proc_mem_arb_id_t last_win;
    logic [7:0]       exp_p_rdata;
    logic [7:0]       exp_d_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_wen_sig) mem[bus.mem_addr_sig] <= bus.mem_wdata_sig;
        bus.mem_rdata_sig <= mem[bus.mem_addr_sig];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic proc_mem_arb_id_t tie_winner();
`ifdef PROC_MEM_ARB_RR_EN
        return (last_win == REQ_PROC) ? REQ_DMA : REQ_PROC;
`else
        return REQ_PROC;
`endif
    endfunction

    function automatic logic [1:0] ack_pat(input proc_mem_arb_id_t id);
        return (id == REQ_PROC) ? 2'b10 : 2'b01;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.p_req_sig = 1'b0; bus.p_addr_sig = '0; bus.p_wdata_sig = '0; bus.p_wen_sig = 1'b0;
        bus.d_req_sig = 1'b0; bus.d_addr_sig = '0; bus.d_wdata_sig = '0; bus.d_wen_sig = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if ({bus.p_ack_sig, bus.d_ack_sig, bus.mem_wen_sig, bus.gnt_id_sig,
                 bus.mem_addr_sig, bus.mem_wdata_sig, bus.p_rdata_sig, bus.d_rdata_sig} !== 36'h0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%h want 0", i,
                         {bus.p_ack_sig, bus.d_ack_sig, bus.mem_wen_sig, bus.gnt_id_sig,
                          bus.mem_addr_sig, bus.mem_wdata_sig, bus.p_rdata_sig, bus.d_rdata_sig});
            end
        end
        exp_p_rdata = 8'h00;
        exp_d_rdata = 8'h00;
        last_win    = REQ_DMA;
    endtask

    task automatic test_proc_read;
        bus.p_addr_sig = 8'h10; bus.p_wen_sig = 1'b0; bus.p_req_sig = 1'b1;
        cyc();
        n_checks++;
        if (bus.mem_addr_sig !== 8'h10) begin
            n_fail++; $display("FAIL pread_addr: got %h want 10", bus.mem_addr_sig);
        end
        n_checks++;
        if ({bus.p_ack_sig, bus.mem_wen_sig, bus.gnt_id_sig} !== 3'b000) begin
            n_fail++; $display("FAIL pread_access_ctl: ack/wen/gnt=%b want 000",
                               {bus.p_ack_sig, bus.mem_wen_sig, bus.gnt_id_sig});
        end
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.d_ack_sig} !== 2'b10) begin
            n_fail++; $display("FAIL pread_ack: got %b want 10", {bus.p_ack_sig, bus.d_ack_sig});
        end
        n_checks++;
        if (bus.p_rdata_sig !== 8'hA5) begin
            n_fail++; $display("FAIL pread_rdata: got %h want a5", bus.p_rdata_sig);
        end
        bus.p_req_sig = 1'b0;
        exp_p_rdata = 8'hA5;
        last_win    = REQ_PROC;
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.p_rdata_sig} !== {1'b0, exp_p_rdata}) begin
            n_fail++; $display("FAIL pread_hold: ack,rdata=%b,%h want 0,%h",
                               bus.p_ack_sig, bus.p_rdata_sig, exp_p_rdata);
        end
    endtask

    // Both request in one IDLE cycle: processor reads 0x30 (c3), DMA reads 0x20 (5a).
    task automatic both_round(input proc_mem_arb_id_t first);
        proc_mem_arb_id_t second;
        logic [7:0] got;
        second = (first == REQ_PROC) ? REQ_DMA : REQ_PROC;
        bus.p_addr_sig = 8'h30; bus.p_wen_sig = 1'b0; bus.p_req_sig = 1'b1;
        bus.d_addr_sig = 8'h20; bus.d_wen_sig = 1'b0; bus.d_req_sig = 1'b1;
        cyc();
        n_checks++;
        if (bus.gnt_id_sig !== logic'(first)) begin
            n_fail++; $display("FAIL tie_gnt: got %b want %b", bus.gnt_id_sig, logic'(first));
        end
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.d_ack_sig} !== ack_pat(first)) begin
            n_fail++; $display("FAIL tie_first_ack: got %b want %b",
                               {bus.p_ack_sig, bus.d_ack_sig}, ack_pat(first));
        end
        got = (first == REQ_PROC) ? bus.p_rdata_sig : bus.d_rdata_sig;
        n_checks++;
        if (got !== ((first == REQ_PROC) ? 8'hC3 : 8'h5A)) begin
            n_fail++; $display("FAIL tie_first_rdata: got %h want %h", got,
                               (first == REQ_PROC) ? 8'hC3 : 8'h5A);
        end
        if (first == REQ_PROC) bus.p_req_sig = 1'b0; else bus.d_req_sig = 1'b0;
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.d_ack_sig, bus.gnt_id_sig} !== {2'b00, logic'(second)}) begin
            n_fail++; $display("FAIL tie_second_access: acks,gnt=%b want 00%b",
                               {bus.p_ack_sig, bus.d_ack_sig, bus.gnt_id_sig}, logic'(second));
        end
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.d_ack_sig} !== ack_pat(second)) begin
            n_fail++; $display("FAIL tie_second_ack: got %b want %b",
                               {bus.p_ack_sig, bus.d_ack_sig}, ack_pat(second));
        end
        got = (second == REQ_PROC) ? bus.p_rdata_sig : bus.d_rdata_sig;
        n_checks++;
        if (got !== ((second == REQ_PROC) ? 8'hC3 : 8'h5A)) begin
            n_fail++; $display("FAIL tie_second_rdata: got %h want %h", got,
                               (second == REQ_PROC) ? 8'hC3 : 8'h5A);
        end
        bus.p_req_sig = 1'b0; bus.d_req_sig = 1'b0;
        exp_p_rdata = 8'hC3;
        exp_d_rdata = 8'h5A;
        last_win    = second;
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.d_ack_sig} !== 2'b00) begin
            n_fail++; $display("FAIL tie_idle: acks=%b want 00", {bus.p_ack_sig, bus.d_ack_sig});
        end
    endtask

    task automatic test_simultaneous;
        both_round(tie_winner());
        both_round(tie_winner());
    endtask

    task automatic test_dma_write;
        bus.d_addr_sig = 8'h80; bus.d_wdata_sig = 8'h3C; bus.d_wen_sig = 1'b1; bus.d_req_sig = 1'b1;
        cyc();
        n_checks++;
        if ({bus.mem_wen_sig, bus.gnt_id_sig, bus.mem_addr_sig, bus.mem_wdata_sig} !== {2'b11, 8'h80, 8'h3C}) begin
            n_fail++; $display("FAIL dwrite_access: wen,gnt,addr,data=%b,%b,%h,%h want 1,1,80,3c",
                               bus.mem_wen_sig, bus.gnt_id_sig, bus.mem_addr_sig, bus.mem_wdata_sig);
        end
        cyc();
        n_checks++;
        if ({bus.d_ack_sig, bus.p_ack_sig, bus.mem_wen_sig} !== 3'b100) begin
            n_fail++; $display("FAIL dwrite_ack: dack,pack,wen=%b want 100",
                               {bus.d_ack_sig, bus.p_ack_sig, bus.mem_wen_sig});
        end
        n_checks++;
        if (bus.d_rdata_sig !== exp_d_rdata) begin
            n_fail++; $display("FAIL dwrite_rdata_kept: got %h want %h", bus.d_rdata_sig, exp_d_rdata);
        end
        bus.d_req_sig = 1'b0; bus.d_wen_sig = 1'b0;
        last_win = REQ_DMA;
        cyc();
        n_checks++;
        if ({bus.mem_wen_sig, mem[8'h80]} !== {1'b0, 8'h3C}) begin
            n_fail++; $display("FAIL dwrite_done: wen,mem[80]=%b,%h want 0,3c", bus.mem_wen_sig, mem[8'h80]);
        end
    endtask

    // Processor holds req continuously; DMA also requests: acks must alternate.
    task automatic test_back_to_back;
        proc_mem_arb_id_t first;
        proc_mem_arb_id_t second;
        logic [1:0] exp_ack;
        first  = tie_winner();
        second = (first == REQ_PROC) ? REQ_DMA : REQ_PROC;
        bus.p_addr_sig = 8'h10; bus.p_wen_sig = 1'b0; bus.p_req_sig = 1'b1;
        bus.d_addr_sig = 8'h20; bus.d_wen_sig = 1'b0; bus.d_req_sig = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp_ack = 2'b00;
            if (k % 4 == 2) exp_ack = ack_pat(first);
            if (k % 4 == 0) exp_ack = ack_pat(second);
            n_checks++;
            if ({bus.p_ack_sig, bus.d_ack_sig} !== exp_ack) begin
                n_fail++; $display("FAIL b2b_ack cycle %0d: got %b want %b", k,
                                   {bus.p_ack_sig, bus.d_ack_sig}, exp_ack);
            end
        end
        bus.p_req_sig = 1'b0; bus.d_req_sig = 1'b0;
        exp_p_rdata = 8'hA5;
        exp_d_rdata = 8'h5A;
        last_win    = second;
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.d_ack_sig, bus.p_rdata_sig, bus.d_rdata_sig} !== {2'b00, exp_p_rdata, exp_d_rdata}) begin
            n_fail++; $display("FAIL b2b_end: acks,prd,drd=%b,%h,%h want 00,%h,%h",
                               {bus.p_ack_sig, bus.d_ack_sig}, bus.p_rdata_sig, bus.d_rdata_sig,
                               exp_p_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_reset_mid;
        bus.p_addr_sig = 8'h44; bus.p_wdata_sig = 8'h99; bus.p_wen_sig = 1'b1; bus.p_req_sig = 1'b1;
        cyc();
        n_checks++;
        if (bus.mem_wen_sig !== 1'b1) begin
            n_fail++; $display("FAIL rmid_access_wen: got %b want 1", bus.mem_wen_sig);
        end
        rst = 1'b1;
        bus.p_req_sig = 1'b0; bus.p_wen_sig = 1'b0;
        cyc();
        n_checks++;
        if ({bus.mem_wen_sig, bus.p_ack_sig, bus.d_ack_sig} !== 3'b000) begin
            n_fail++; $display("FAIL rmid_no_ack: wen,pack,dack=%b want 000",
                               {bus.mem_wen_sig, bus.p_ack_sig, bus.d_ack_sig});
        end
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL rmid_state: got %0d want %0d", dut.state_q, IDLE);
        end
        n_checks++;
        if ({bus.p_rdata_sig, bus.d_rdata_sig, bus.mem_addr_sig} !== 24'h0) begin
            n_fail++; $display("FAIL rmid_regs: prd,drd,addr=%h,%h,%h want 0",
                               bus.p_rdata_sig, bus.d_rdata_sig, bus.mem_addr_sig);
        end
        rst = 1'b0;
        exp_p_rdata = 8'h00;
        cyc();
        n_checks++;
        if ({bus.mem_wen_sig, bus.p_ack_sig} !== 2'b00) begin
            n_fail++; $display("FAIL rmid_after: wen,ack=%b want 00", {bus.mem_wen_sig, bus.p_ack_sig});
        end
        bus.p_addr_sig = 8'h10; bus.p_wen_sig = 1'b0; bus.p_req_sig = 1'b1;
        cyc();
        n_checks++;
        if (bus.mem_addr_sig !== 8'h10) begin
            n_fail++; $display("FAIL rmid_new_addr: got %h want 10", bus.mem_addr_sig);
        end
        cyc();
        n_checks++;
        if ({bus.p_ack_sig, bus.p_rdata_sig} !== {1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL rmid_new_ack: ack,rdata=%b,%h want 1,a5", bus.p_ack_sig, bus.p_rdata_sig);
        end
        bus.p_req_sig = 1'b0;
        cyc();
        n_checks++;
        if (bus.p_ack_sig !== 1'b0) begin
            n_fail++; $display("FAIL rmid_new_done: ack=%b want 0", bus.p_ack_sig);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h20] = 8'h5A;
        mem[8'h30] = 8'hC3;

        test_reset();
        test_proc_read();
        test_simultaneous();
        test_dma_write();
        test_back_to_back();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
